// File: rtl/cam_stream_ctrl.sv
// cam_stream_ctrl: frames the camera vsync/href byte stream, packs YUYV
// byte pairs into 4-bit grayscale pixels for the 3-row line buffer, pads
// short lines so the buffer's column counter stays aligned, and reports
// line/frame geometry errors.
module cam_stream_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic       cam_de,
  input  logic [7:0] cam_data,
  output logic [3:0] pixel_out,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       line_err,
  output logic       frame_err,
  output logic [7:0] frame_count,
  output logic       busy
);

  localparam logic [10:0] COLW    = 11'(WIDTH);
  localparam logic [10:0] COL_SAT = 11'(WIDTH + 1);
  localparam logic [9:0]  ROWH    = 10'(HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VS, S_VBLANK, S_ACTIVE, S_PAD
  } state_t;

  state_t      state_q, state_d;
  logic        vs_q, hr_q;
  logic [10:0] col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic        phase_q, phase_d;
  logic        skip_q, skip_d;
  logic [3:0]  y_q, y_d;
  logic [3:0]  pix_q, pix_d;
  logic        pv_q, pv_d;
  logic        fs_q, fs_d;
  logic        fd_q, fd_d;
  logic        le_q, le_d;
  logic        fe_q, fe_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        busy_q, busy_d;

  // Chroma and the low luma bits are intentionally discarded.
  logic unused_lo;
  assign unused_lo = ^cam_data[3:0];

  logic vs_rise, vs_fall, hr_fall, byte_ok, in_frame, col_lt, row_lt;
  logic [10:0] col_inc;
  logic [9:0]  row_inc;

  assign vs_rise  = cam_vsync & ~vs_q;
  assign vs_fall  = ~cam_vsync & vs_q;
  assign hr_fall  = hr_q & ~cam_href;
  assign byte_ok  = cam_de & cam_href;
  assign in_frame = (state_q == S_ACTIVE) || (state_q == S_PAD);
  assign col_lt   = col_q < COLW;
  assign row_lt   = row_q < ROWH;
  assign col_inc  = (col_q == COL_SAT) ? col_q : col_q + 11'd1;
  assign row_inc  = (row_q == 10'd1023) ? row_q : row_q + 10'd1;

  // Next-state, counters and registered-output pulses.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    phase_d = phase_q;
    skip_d  = skip_q;
    y_d     = y_q;
    pix_d   = 4'd0;
    pv_d    = 1'b0;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    le_d    = 1'b0;
    fe_d    = 1'b0;
    fcnt_d  = fcnt_q;

    if (in_frame && vs_rise) begin
      // Frame end wins over any href fall in the same cycle; a partial
      // line is flagged but never padded.
      fd_d    = 1'b1;
      fe_d    = (row_q != ROWH);
      fcnt_d  = fcnt_q + 8'd1;
      le_d    = (state_q == S_ACTIVE) && (col_q != 11'd0) && !skip_q;
      state_d = enable ? S_VBLANK : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (enable) state_d = S_WAIT_VS;
        S_WAIT_VS: if (vs_rise) state_d = S_VBLANK;
        S_VBLANK: begin
          if (vs_fall) begin
            fs_d    = 1'b1;
            col_d   = 11'd0;
            row_d   = 10'd0;
            phase_d = 1'b0;
            skip_d  = 1'b0;
            state_d = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (hr_fall) begin
            phase_d = 1'b0;
            if (skip_q) begin
              skip_d = 1'b0;
              col_d  = 11'd0;
            end else begin
              le_d = (col_q != COLW);
              if (col_lt && row_lt) begin
                // First pad pixel goes out alongside line_err.
                pv_d    = 1'b1;
                col_d   = col_q + 11'd1;
                state_d = S_PAD;
              end else begin
                row_d = row_inc;
                col_d = 11'd0;
              end
            end
          end else if (byte_ok) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
              y_d = cam_data[7:4];
            end else if (!skip_q) begin
              if (col_lt && row_lt) begin
                pv_d  = 1'b1;
                pix_d = y_q;
              end
              col_d = col_inc;
            end
          end
        end
        S_PAD: begin
          if (col_lt) begin
            pv_d  = 1'b1;
            col_d = col_q + 11'd1;
          end else begin
            // A line that already started while padding is discarded whole.
            row_d   = row_inc;
            col_d   = 11'd0;
            skip_d  = cam_href;
            state_d = S_ACTIVE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // State, edge-detect history and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      col_q   <= 11'd0;
      row_q   <= 10'd0;
      phase_q <= 1'b0;
      skip_q  <= 1'b0;
      y_q     <= 4'd0;
      pix_q   <= 4'd0;
      pv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      le_q    <= 1'b0;
      fe_q    <= 1'b0;
      fcnt_q  <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= cam_vsync;
      hr_q    <= cam_href;
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      skip_q  <= skip_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      le_q    <= le_d;
      fe_q    <= fe_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
    end
  end

  assign pixel_out   = pix_q;
  assign pixel_valid = pv_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign line_err    = le_q;
  assign frame_err   = fe_q;
  assign frame_count = fcnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cam_stream_ctrl.sv
// Bench for cam_stream_ctrl with a 4x3 image: table of whole-frame
// scenarios plus hand sequences for latency, padding and reset.
module tb_cam_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       cam_vsync = 1'b0;
  logic       cam_href = 1'b0;
  logic       cam_de = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic [3:0] pixel_out;
  logic       pixel_valid, frame_start, frame_done, line_err, frame_err, busy;
  logic [7:0] frame_count;

  cam_stream_ctrl #(.WIDTH(4), .HEIGHT(3)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_de(cam_de),
    .cam_data(cam_data), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err),
    .frame_err(frame_err), .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Running event totals seen by the monitor.
  int pv_tot = 0, le_tot = 0, fe_tot = 0, fd_tot = 0, fs_tot = 0, both_tot = 0;
  logic [3:0] pix_hist [1024];

  always @(negedge clk) begin
    if (pixel_valid) begin
      pix_hist[pv_tot % 1024] = pixel_out;
      pv_tot = pv_tot + 1;
    end
    if (line_err)    le_tot = le_tot + 1;
    if (frame_err)   fe_tot = fe_tot + 1;
    if (frame_done)  fd_tot = fd_tot + 1;
    if (frame_start) fs_tot = fs_tot + 1;
    if (frame_done && frame_err) both_tot = both_tot + 1;
  end

  typedef struct {
    int              nlines;
    logic [3:0][7:0] len;
    logic [3:0][7:0] gap;
    logic [15:0]     bases;   // line0 luma base in [15:12]
    logic            en;
    int              exp_pix;
    logic [47:0]     exp_seq; // first pixel in [47:44]
    int              exp_lerr;
    int              exp_ferr;
    int              exp_fcnt;
    logic            exp_busy;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input int n, input int l0, input int l1,
                              input int l2, input int l3, input int g0,
                              input int g1, input int g2, input int g3,
                              input logic [15:0] b, input logic en,
                              input int pix, input logic [47:0] seq,
                              input int lerr, input int ferr, input int fcnt,
                              input logic bsy);
    vec_t r;
    r.nlines = n;
    r.len[0] = 8'(l0); r.len[1] = 8'(l1); r.len[2] = 8'(l2); r.len[3] = 8'(l3);
    r.gap[0] = 8'(g0); r.gap[1] = 8'(g1); r.gap[2] = 8'(g2); r.gap[3] = 8'(g3);
    r.bases = b; r.en = en; r.exp_pix = pix; r.exp_seq = seq;
    r.exp_lerr = lerr; r.exp_ferr = ferr; r.exp_fcnt = fcnt; r.exp_busy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int idx);
    vec_t v;
    int s_pv, s_le, s_fe, s_fd, s_fs, s_both, n;
    logic [47:0] act_seq;
    logic [3:0] base;
    v = tbl[idx];
    s_pv = pv_tot; s_le = le_tot; s_fe = fe_tot;
    s_fd = fd_tot; s_fs = fs_tot; s_both = both_tot;
    cam_vsync = 1'b1; cam_href = 1'b0; cam_de = 1'b0;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
    enable = v.en;
    for (int l = 0; l < v.nlines; l++) begin
      base = v.bases[15 - 4*l -: 4];
      for (int b = 0; b < int'(v.len[l]); b++) begin
        cam_href = 1'b1; cam_de = 1'b1;
        cam_data = (b % 2 == 0) ? {base + 4'(b / 2), 4'h0} : 8'hF7;
        tick();
      end
      cam_href = 1'b0; cam_de = 1'b0;
      repeat (int'(v.gap[l])) tick();
    end
    cam_vsync = 1'b1;
    repeat (4) tick();
    n = pv_tot - s_pv;
    act_seq = '0;
    for (int k = 0; k < n && k < 12; k++)
      act_seq[47 - 4*k -: 4] = pix_hist[(s_pv + k) % 1024];
    $display("scenario %0d", idx);
    chk("pixel_count",   64'(n), 64'(v.exp_pix));
    chk("pixel_seq",     64'(act_seq), 64'(v.exp_seq));
    chk("line_err_cnt",  64'(le_tot - s_le), 64'(v.exp_lerr));
    chk("frame_err_cnt", 64'(fe_tot - s_fe), 64'(v.exp_ferr));
    chk("done_with_err", 64'(both_tot - s_both), 64'(v.exp_ferr));
    chk("frame_done_cnt",64'(fd_tot - s_fd), 64'd1);
    chk("frame_start_cnt",64'(fs_tot - s_fs), 64'd1);
    chk("frame_count",   64'(frame_count), 64'(v.exp_fcnt));
    chk("busy_after",    64'(busy), 64'(v.exp_busy));
  endtask

  initial begin
    tbl[0] = mk(3, 8,8,8,0,  6,6,6,0, 16'hAAA0, 1'b1, 12, 48'hABCDABCDABCD, 0,0,1, 1'b1);
    tbl[1] = mk(3, 8,4,8,0,  6,6,6,0, 16'hA5A0, 1'b1, 12, 48'hABCD5600ABCD, 1,0,2, 1'b1);
    tbl[2] = mk(3, 12,8,8,0, 6,6,6,0, 16'hAAA0, 1'b1, 12, 48'hABCDABCDABCD, 1,0,3, 1'b1);
    tbl[3] = mk(2, 8,8,0,0,  6,6,0,0, 16'hAA00, 1'b1,  8, 48'hABCDABCD0000, 0,1,4, 1'b1);
    tbl[4] = mk(4, 8,4,8,8,  6,1,6,6, 16'hA51C, 1'b1, 12, 48'hABCD5600CDEF, 1,0,5, 1'b1);
    tbl[5] = mk(3, 8,8,8,0,  6,6,6,0, 16'hAAA0, 1'b0, 12, 48'hABCDABCDABCD, 0,0,6, 1'b0);

    // Reset state
    repeat (3) tick();
    chk("reset_outputs", 64'({pixel_out, pixel_valid, frame_start, frame_done,
                              line_err, frame_err, frame_count, busy}), 64'd0);
    rst = 1'b0;
    enable = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_frame(i);

    // Latency, padding timing and mid-line reset, starting from IDLE.
    enable = 1'b1; cam_vsync = 1'b0;
    tick(); tick();
    cam_vsync = 1'b1; tick(); tick();
    cam_vsync = 1'b0; tick();
    chk("frame_start_pulse", 64'({frame_start, pixel_valid}), 64'b10);
    cam_href = 1'b1; cam_de = 1'b1; cam_data = 8'h90; tick();
    chk("phase0_no_pixel", 64'({frame_start, pixel_valid}), 64'b00);
    cam_data = 8'h11; tick();
    chk("pixel_latency", 64'({pixel_valid, pixel_out}), 64'h19);
    cam_data = 8'h20; tick();
    cam_data = 8'h22; tick();
    chk("second_pixel", 64'({pixel_valid, pixel_out}), 64'h12);
    cam_href = 1'b0; cam_de = 1'b0; tick();
    chk("pad_with_line_err", 64'({line_err, pixel_valid, pixel_out}), 64'h30);
    tick();
    chk("pad_back_to_back", 64'({line_err, pixel_valid, pixel_out}), 64'h10);
    tick();
    chk("pad_exit", 64'(pixel_valid), 64'd0);
    cam_href = 1'b1; cam_de = 1'b1; cam_data = 8'hE0; tick();
    cam_data = 8'h11; tick();
    chk("row1_pixel", 64'({pixel_valid, pixel_out}), 64'h1E);
    #1 rst = 1'b1;
    cam_vsync = 1'b1;
    #1;
    chk("async_reset", 64'({pixel_out, pixel_valid, frame_start, frame_done,
                            line_err, frame_err, frame_count, busy}), 64'd0);
    tick();
    chk("held_reset", 64'({pixel_out, pixel_valid, frame_start, frame_done,
                           line_err, frame_err, frame_count, busy}), 64'd0);
    rst = 1'b0; cam_href = 1'b0; cam_de = 1'b0;
    tick();
    chk("no_done_after_rst", 64'({frame_done, pixel_valid, frame_count}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_stream_ctrl.md
# cam_stream_ctrl

Sequencer between the camera byte interface and the 3-row line buffer. Frames the camera's vsync/href byte stream and packs YUYV byte pairs into 4-bit grayscale pixels. Drives the line buffer's `pixel_in`/`pixel_valid`/`frame_start` so the buffer's column counter stays aligned with the image even when camera lines are short or long. Reports line and frame geometry errors and counts completed frames.

## Interface
- `WIDTH`, 640: pixels per line delivered downstream.
- `HEIGHT`, 480: lines per frame delivered downstream.
- `clk`  in  1  system clock; camera signals already synchronised to it.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  arm capture; sampled only in IDLE and at frame end.
- `cam_vsync`  in  1  high during vertical blanking.
- `cam_href`  in  1  high while line bytes are active.
- `cam_de`  in  1  byte strobe; `cam_data` is valid when `cam_de & cam_href`.
- `cam_data`  in  8  YUYV byte stream, Y first.
- `pixel_out`  out  4  grayscale pixel to the line buffer.
- `pixel_valid`  out  1  one-cycle qualifier for `pixel_out`.
- `frame_start`  out  1  one-cycle pulse that resets the line buffer counters.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.
- `line_err`  out  1  one-cycle pulse when a line is short or long.
- `frame_err`  out  1  one-cycle pulse when the line count is not `HEIGHT`.
- `frame_count`  out  8  completed frames; wraps 255→0.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Registered copies `vs_q` and `hr_q` provide edge detection. Fall = q&!in; rise = !q&in.
- **IDLE**: if `enable`, go to WAIT_VS.
- **WAIT_VS**: wait for a vsync rise, then go to VBLANK. Mid-frame data arriving after enable is never captured.
- **VBLANK**: on a vsync fall:
  - pulse `frame_start`;
  - clear `col` (11 bit), `row` (10 bit), the byte phase and `skip`;
  - go to ACTIVE.
- **ACTIVE**:
  - Each accepted byte toggles the byte phase.
  - Phase 0 byte: `cam_data[7:4]` is latched as Y.
  - Phase 1 byte: if `col<WIDTH` and `row<HEIGHT` and `!skip`, emit the latched Y as a pixel. `col` increments, saturating at `WIDTH+1`.
  - Bytes past `WIDTH` pixels, or in lines past `HEIGHT`, are dropped without a pixel.
  - On an href fall:
    - the byte phase resets;
    - if `skip` is set, clear it and count nothing;
    - otherwise, if `col!=WIDTH`, pulse `line_err`;
    - if `col<WIDTH` and `row<HEIGHT`, go to PAD;
    - otherwise `row` increments (saturating at 1023) and `col` clears.
  - On a vsync rise:
    - pulse `frame_done`;
    - pulse `frame_err` if `row!=HEIGHT`;
    - increment `frame_count`;
    - go to VBLANK if `enable`, else IDLE.
- **PAD**:
  - Emit `pixel_out=0` with `pixel_valid=1` every cycle until `col==WIDTH`.
  - Then increment `row`, clear `col`, and return to ACTIVE.
  - If `cam_href` is high on the exit cycle, set `skip`; that whole line is discarded and is not counted in `row`.
  - All camera bytes that arrive during PAD are dropped.
- A vsync rise has priority over an href fall in the same cycle. The partial line is not padded; `line_err` pulses if `col` is non-zero.
- `enable` deasserting mid-frame has no effect until the vsync rise.

## Timing
- All outputs are registered.
- Reset value is 0 for every output and counter; the state is IDLE.
- `pixel_valid` rises in the cycle after the phase-1 byte is sampled: 1-cycle latency.
- `frame_start` is high in the cycle after the first sample of `cam_vsync=0`. It always precedes the first `pixel_valid` of the frame by at least 1 cycle.
- `line_err` is high the cycle after the first sample of `cam_href=0`. PAD pixels begin in that same cycle and continue back-to-back, one per clock.
- `frame_done`, `frame_err` and `frame_count` all update in the same cycle: the cycle after the vsync rise is sampled.
- `pixel_valid` is never asserted outside ACTIVE or PAD, and never more than `WIDTH` times per line.
- Asserting `rst` at any point returns the block to IDLE within the same cycle; no further pulses follow.

## Test plan
- **Nominal frame**: `WIDTH=4`, `HEIGHT=3`, 3 lines of 8 bytes with Y=0x A0,B0,C0,D0 → 12 `pixel_valid` pulses, `pixel_out` A,B,C,D per line, one `frame_start`, one `frame_done`, `frame_count`=1, no errors.
- **Short line**: line 2 has 4 bytes (Y=0x50,0x60) → pixels 5,6 then 2 pad zeros on consecutive cycles, `line_err`=1 once, total 12 pixels, no `frame_err`.
- **Long line**: line 1 has 12 bytes → only 4 pixels emitted, `line_err` pulses once, `row` ends at 3.
- **Missing line**: only 2 lines, then vsync rise → `frame_done` and `frame_err` in the same cycle, `frame_count` increments.
- **Href during PAD**: short line followed by href rising 1 cycle later → that next line produces no pixels, the third line is emitted as row 2.
- **Enable/reset**: drop `enable` mid-frame → frame completes, then IDLE with `busy`=0; assert `rst` mid-line → all outputs 0 next edge, no `frame_done`.
